davinci_instr_arbiter: RTL and testbench

//  Shares the single DA-VinCi instruction port between NUM_REQ instruction sources (host FIFO, preload

---
 rtl/davinci_instr_arbiter_if.sv | 29 ++
 rtl/davinci_instr_arbiter.sv | 121 ++++++++++++
 tb/tb_davinci_instr_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/davinci_instr_arbiter_if.sv
// davinci_instr_arbiter_if: requester-side and instruction-port handshake bundle.
//  master: the arbiter (consumes requester words, drives the instruction port)
//  slave : the environment (requester FIFO heads and the davinci_wrapper consume signal)
//  reqInstruction   NUM_REQ*INSTR_WIDTH  per-requester word, req i at [i*INSTR_WIDTH +: INSTR_WIDTH]
//  reqValid/reqLast NUM_REQ              FWFT head valid / word closes its burst
//  reqNext          NUM_REQ              pop pulse, word of req i captured this cycle
//  instruction, instructionValid, instructionNext  registered instruction port + consume
interface davinci_instr_arbiter_if #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic [NUM_REQ*INSTR_WIDTH-1:0] reqInstruction;
    logic [NUM_REQ-1:0]             reqValid;
    logic [NUM_REQ-1:0]             reqLast;
    logic [NUM_REQ-1:0]             reqNext;
    logic [INSTR_WIDTH-1:0]         instruction;
    logic                           instructionValid;
    logic                           instructionNext;

    modport master (
        input  reqInstruction, reqValid, reqLast, instructionNext,
        output reqNext, instruction, instructionValid
    );

    modport slave (
        output reqInstruction, reqValid, reqLast, instructionNext,
        input  reqNext, instruction, instructionValid
    );
endinterface

// File: rtl/davinci_instr_arbiter.sv
// davinci_instr_arbiter: shares the DA-VinCi instruction port between NUM_REQ sources.
//  Round-robin between sources, bursts locked to one source until its reqLast word,
//  one registered output stage (1-cycle latency, 1 word/cycle throughput).
//  clk, rst      clock, synchronous active-high reset
//  bus           davinci_instr_arbiter_if.master (requester words, pop pulses, instruction port)
//  grantSrc      source index of the word held in the output register
//  locked        burst lock held
//  errBurst      sticky, a burst reached MAX_BURST words without reqLast
module davinci_instr_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned MAX_BURST   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    davinci_instr_arbiter_if.master    bus,
    output logic [$clog2(NUM_REQ)-1:0] grantSrc,
    output logic                       locked,
    output logic                       errBurst
);
    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    logic [SRC_W-1:0]    rrPtr;
    logic [SRC_W-1:0]    lockSrc;
    logic [CNT_W-1:0]    burstCnt;

    logic                consume;
    logic                load;
    logic                selValid;
    logic [SRC_W-1:0]    selSrc;
    logic                capture;
    logic [SRC_W-1:0]    nextPtr;
    logic [INSTR_WIDTH-1:0] selWord;
    int unsigned         scanIdx;

    // Output register may take a new word when empty or being consumed this edge.
    assign consume = bus.instructionValid & bus.instructionNext;
    assign load    = ~bus.instructionValid | consume;

    // Source selection: locked owner only, otherwise first valid from rrPtr onwards.
    always_comb begin
        selValid = 1'b0;
        selSrc   = '0;
        scanIdx  = 0;
        if (state == LOCKED) begin
            selValid = bus.reqValid[lockSrc];
            selSrc   = lockSrc;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scanIdx = 32'(rrPtr) + k;
                if (scanIdx >= NUM_REQ) begin
                    scanIdx = scanIdx - NUM_REQ;
                end
                if (!selValid && bus.reqValid[SRC_W'(scanIdx)]) begin
                    selValid = 1'b1;
                    selSrc   = SRC_W'(scanIdx);
                end
            end
        end
    end

    // Capture is suppressed in reset so no source word is popped and lost.
    assign capture = load & selValid & ~rst;
    assign selWord = bus.reqInstruction[selSrc*INSTR_WIDTH +: INSTR_WIDTH];
    assign nextPtr = (32'(selSrc) == NUM_REQ - 1) ? '0 : selSrc + 1'b1;

    // Pop pulse back to the chosen source, same cycle as capture.
    always_comb begin
        bus.reqNext = '0;
        if (capture) begin
            bus.reqNext[selSrc] = 1'b1;
        end
    end

    // Output stage, lock FSM, round-robin pointer and burst watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.instruction      <= '0;
            bus.instructionValid <= 1'b0;
            grantSrc             <= '0;
            state                <= IDLE;
            rrPtr                <= '0;
            lockSrc              <= '0;
            burstCnt             <= '0;
            errBurst             <= 1'b0;
        end else begin
            if (load) begin
                bus.instructionValid <= capture;
            end
            if (capture) begin
                bus.instruction <= selWord;
                grantSrc        <= selSrc;
                if (bus.reqLast[selSrc]) begin
                    state    <= IDLE;
                    rrPtr    <= nextPtr;
                    burstCnt <= '0;
                end else begin
                    if (burstCnt == CNT_W'(MAX_BURST - 1)) begin
                        errBurst <= 1'b1;
                    end
                    if (state == IDLE) begin
                        state    <= LOCKED;
                        lockSrc  <= selSrc;
                        burstCnt <= CNT_W'(1);
                    end else if (burstCnt != CNT_W'(MAX_BURST)) begin
                        burstCnt <= burstCnt + 1'b1;
                    end
                end
            end
        end
    end

    assign locked = (state == LOCKED);
endmodule

// File: tb/tb_davinci_instr_arbiter.sv
// tb_davinci_instr_arbiter: directed scenarios plus random traffic, every cycle checked
//  against a transaction-level model (per-source word queues, lock owner, rotation pointer).
module tb_davinci_instr_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned IW = 32;
    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] grantSrc;
    logic       locked;
    logic       errBurst;

    davinci_instr_arbiter_if #(.NUM_REQ(NR), .INSTR_WIDTH(IW)) bus ();

    davinci_instr_arbiter #(
        .NUM_REQ(NR), .INSTR_WIDTH(IW), .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .grantSrc(grantSrc),
        .locked(locked),
        .errBurst(errBurst)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Source FIFOs: {last, word}; gate[i]=0 forces a bubble on that source.
    logic [32:0] q [NR][$];
    bit          gate [NR];

    // Reference model state.
    logic        mValid;
    logic [31:0] mInstr;
    int          mGrant;
    int          lockOwner;
    int          rr;
    int          burstLen;
    logic        mErr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0; mInstr = '0; mGrant = 0;
        lockOwner = -1; rr = 0; burstLen = 0; mErr = 1'b0;
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NR; i++) begin
            logic [32:0] h;
            h = 33'({$urandom_range(0, 1), $urandom});
            if (q[i].size() > 0) h = q[i][0];
            bus.reqValid[i] = gate[i] && (q[i].size() > 0);
            bus.reqLast[i]  = h[32];
            bus.reqInstruction[i*IW +: IW] = h[31:0];
        end
    endtask

    task automatic push(input int src, input logic [31:0] w, input logic last);
        q[src].push_back({last, w});
    endtask

    // One clock cycle: starts and ends just after a negedge.
    task automatic cycle(input logic nxt);
        int          sel;
        logic        ld;
        logic [NR-1:0] expNext;
        logic [NR-1:0] dutNext;
        logic [32:0] selItem;
        driveInputs();
        bus.instructionNext = nxt;
        #1;
        sel = -1;
        selItem = '0;
        if (!rst) begin
            if (lockOwner >= 0) begin
                if (gate[lockOwner] && q[lockOwner].size() > 0) sel = lockOwner;
            end else begin
                for (int o = 0; o < NR; o++) begin
                    int c;
                    c = (rr + o) % NR;
                    if (sel < 0 && gate[c] && q[c].size() > 0) sel = c;
                end
            end
        end
        ld = !mValid || nxt;
        expNext = '0;
        if (ld && sel >= 0) begin
            expNext[sel] = 1'b1;
            selItem = q[sel][0];
        end
        dutNext = bus.reqNext;
        check("reqNext", 64'(dutNext), 64'(expNext));
        @(posedge clk);
        for (int i = 0; i < NR; i++) begin
            if (dutNext[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (rst) begin
            modelReset();
        end else if (ld) begin
            mValid = (sel >= 0);
            if (sel >= 0) begin
                mInstr = selItem[31:0];
                mGrant = sel;
                if (selItem[32]) begin
                    lockOwner = -1; rr = (sel + 1) % NR; burstLen = 0;
                end else begin
                    lockOwner = sel; burstLen++;
                    if (burstLen >= MB) mErr = 1'b1;
                end
            end
        end
        #1;
        check("instructionValid", 64'(bus.instructionValid), 64'(mValid));
        check("instruction", 64'(bus.instruction), 64'(mInstr));
        check("grantSrc", 64'(grantSrc), 64'(mGrant));
        check("locked", 64'(locked), 64'(lockOwner >= 0));
        check("errBurst", 64'(errBurst), 64'(mErr));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.instructionNext = 1'b0;
        for (int i = 0; i < NR; i++) gate[i] = 1'b0;
        modelReset();
        driveInputs();
        @(negedge clk);
        cycle(1'b1);
        rst = 1'b0;

        // 1: single words from req0
        gate[0] = 1'b1;
        push(0, 32'hAAAA_0001, 1'b1);
        push(0, 32'hBBBB_0002, 1'b1);
        repeat (4) cycle(1'b1);

        // 2: two single-word streams alternate
        for (int k = 0; k < 4; k++) begin
            push(0, 32'h1000_0000 + 32'(k), 1'b1);
            push(1, 32'h2000_0000 + 32'(k), 1'b1);
        end
        gate[0] = 1'b1; gate[1] = 1'b1;
        repeat (9) cycle(1'b1);

        // 3: req0 burst with a bubble, req1 must wait
        push(0, 32'hC0DE_0000, 1'b0);
        push(0, 32'hC0DE_0001, 1'b0);
        push(0, 32'hC0DE_0002, 1'b1);
        push(1, 32'hD00D_0000, 1'b1);
        push(1, 32'hD00D_0001, 1'b1);
        gate[0] = 1'b1; gate[1] = 1'b0;
        cycle(1'b1);
        gate[0] = 1'b0; gate[1] = 1'b1;
        cycle(1'b1);
        check("t3_lockedDuringBubble", 64'(locked), 64'(1));
        gate[0] = 1'b1;
        repeat (6) cycle(1'b1);

        // 4: backpressure holds the word, then back-to-back resume
        push(0, 32'hE000_0000, 1'b1);
        push(1, 32'hE000_0001, 1'b1);
        push(0, 32'hE000_0002, 1'b1);
        cycle(1'b1);
        repeat (5) cycle(1'b0);
        repeat (5) cycle(1'b1);

        // 5: over-long burst flags errBurst and keeps the lock
        gate[1] = 1'b0;
        for (int k = 0; k < 5; k++) push(0, 32'hF000_0000 + 32'(k), 1'b0);
        push(1, 32'h1111_1111, 1'b1);
        repeat (6) cycle(1'b1);
        check("t5_errBurst", 64'(errBurst), 64'(1));
        check("t5_lockHeld", 64'(locked), 64'(1));

        // 6: reset mid-burst, req0 source flushed, req1 served first
        push(0, 32'hF000_0005, 1'b0);
        gate[1] = 1'b1;
        cycle(1'b1);
        q[0].delete();
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        check("t6_errCleared", 64'(errBurst), 64'(0));
        cycle(1'b1);
        check("t6_grantReq1", 64'(grantSrc), 64'(1));
        check("t6_validReq1", 64'(bus.instructionValid), 64'(1));
        repeat (3) cycle(1'b1);

        // Random traffic with short bursts, bubbles and backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (q[i].size() < 2) begin
                    int len;
                    len = int'($urandom_range(1, 3));
                    for (int b = 0; b < len; b++) push(i, $urandom, (b == len - 1));
                end
                gate[i] = ($urandom_range(0, 3) != 0);
            end
            cycle($urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
